// File: rtl/random_pkg.sv
`default_nettype none
// ============================================================================
// Module      : random_pkg
// Description : Shared types and constants for the random-module datapath:
//               tap_lfsr FSM state encoding and the tap-field / output-byte
//               widths.
// Revision    : 1.0 - initial release
// ============================================================================
package random_pkg;

    // Width of one tap field inside the packed tap vector
    localparam int TAP_W = 8;

    // Width of one generated output byte
    localparam int OUT_W = 8;

    // Generator state machine encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage : random_pkg
`default_nettype wire

// File: rtl/tap_mask_builder.sv
`default_nettype none
// ============================================================================
// Module      : tap_mask_builder
// Description : Walks the packed tap vector one field per cycle while the
//               generator is in LOAD, and flags fields that name a usable
//               feedback tap.
//   clk       in  rising-edge clock
//   res       in  synchronous active-low reset
//   start_i   in  LOAD is being entered this cycle; rewind to field 0
//   active_i  in  LOAD cycle with enable; handle current field, then advance
//   taps_i    in  packed tap fields, field k = bits [8k+7:8k]
//   set_o     out current field is in range 1..SIZE-1; set its mask bit
//   set_bit_o out mask bit index to set (tap value - 1)
//   last_o    out current field is the final one
// Revision    : 1.0 - initial release
// ============================================================================
module tap_mask_builder
    import random_pkg::*;
#(
    parameter int NUM_OF_TAPS = 15,
    parameter int SIZE        = 32
) (
    input  logic                         clk,
    input  logic                         res,
    input  logic                         start_i,
    input  logic                         active_i,
    input  logic [NUM_OF_TAPS*TAP_W-1:0] taps_i,
    output logic                         set_o,
    output logic [$clog2(SIZE)-1:0]      set_bit_o,
    output logic                         last_o
);

    localparam int IDX_W = (NUM_OF_TAPS > 1) ? $clog2(NUM_OF_TAPS) : 1;
    localparam int BIT_W = $clog2(SIZE);

    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic [TAP_W-1:0] w_fields [NUM_OF_TAPS];
    logic [TAP_W-1:0] w_field;
    logic             w_in_range;

    // Unpacked view of the tap vector so the field mux is a plain array index
    for (genvar k = 0; k < NUM_OF_TAPS; k++) begin : g_fields
        assign w_fields[k] = taps_i[k*TAP_W +: TAP_W];
    end

    assign w_field = w_fields[idx_q];
    assign last_o  = (idx_q == IDX_W'(NUM_OF_TAPS - 1));

    // Tap 0 and taps at or beyond the register width have no mask bit
    assign w_in_range = (w_field != '0) && (int'(w_field) <= SIZE - 1);
    assign set_o      = active_i && w_in_range;
    assign set_bit_o  = BIT_W'(w_field - 8'd1);

    always_comb begin
        idx_d = idx_q;
        if (start_i) begin
            idx_d = '0;
        end else if (active_i && !last_o) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule : tap_mask_builder
`default_nettype wire

// File: rtl/tap_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : tap_lfsr
// Description : Builds a Fibonacci LFSR feedback mask from the selector's tap
//               vector, seeds the register and streams pseudo-random bytes
//               over a valid/ready handshake.
//   clk        in  rising-edge clock
//   res        in  synchronous active-low reset
//   ena        in  global enable; all state holds when low
//   taps       in  packed 8-bit tap fields
//   taps_done  in  tap vector complete (level)
//   seed       in  initial LFSR state, sampled on LOAD entry
//   reload     in  abandon current run, return to IDLE
//   dout       out generated byte, first bit in dout[7]
//   dout_valid out dout holds an unconsumed byte
//   dout_ready in  downstream accepts dout
//   running    out generator is in RUN
// Revision    : 1.0 - initial release
// ============================================================================
module tap_lfsr
    import random_pkg::*;
#(
    parameter int NUM_OF_TAPS = 15,
    parameter int SIZE        = 32
) (
    input  logic                         clk,
    input  logic                         res,
    input  logic                         ena,
    input  logic [NUM_OF_TAPS*TAP_W-1:0] taps,
    input  logic                         taps_done,
    input  logic [SIZE-1:0]              seed,
    input  logic                         reload,
    output logic [OUT_W-1:0]             dout,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic                         running
);

    localparam int              BIT_W    = $clog2(SIZE);
    localparam logic [SIZE-1:0] ONE      = {{(SIZE-1){1'b0}}, 1'b1};
    localparam logic [SIZE-1:0] MSB_ONLY = {1'b1, {(SIZE-1){1'b0}}};

    state_t           state_q,      state_d;
    logic [SIZE-1:0]  mask_q,       mask_d;
    logic [SIZE-1:0]  lfsr_q,       lfsr_d;
    logic [OUT_W-1:0] acc_q,        acc_d;
    logic [2:0]       cnt_q,        cnt_d;
    logic [OUT_W-1:0] dout_q,       dout_d;
    logic             dout_valid_q, dout_valid_d;

    logic             w_start;
    logic             w_active;
    logic             w_set;
    logic [BIT_W-1:0] w_set_bit;
    logic             w_last;
    logic             w_fb;
    logic             w_backpressure;

    assign w_start  = ena && !reload && (state_q == IDLE) && taps_done;
    assign w_active = ena && !reload && (state_q == LOAD);

    tap_mask_builder #(
        .NUM_OF_TAPS (NUM_OF_TAPS),
        .SIZE        (SIZE)
    ) u_tap_mask_builder (
        .clk       (clk),
        .res       (res),
        .start_i   (w_start),
        .active_i  (w_active),
        .taps_i    (taps),
        .set_o     (w_set),
        .set_bit_o (w_set_bit),
        .last_o    (w_last)
    );

    assign w_fb = ^(lfsr_q & mask_q);

    // The byte-completing shift would overwrite an unconsumed byte, so it
    // waits; every earlier shift of the next byte may proceed meanwhile.
    assign w_backpressure = (cnt_q == 3'd7) && dout_valid_q && !dout_ready;

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        lfsr_d       = lfsr_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;

        if (ena) begin
            if (reload) begin
                // Mask is deliberately kept; LOAD entry rebuilds it anyway
                state_d      = IDLE;
                dout_valid_d = 1'b0;
                cnt_d        = 3'd0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (taps_done) begin
                            state_d = LOAD;
                            mask_d  = MSB_ONLY;
                            lfsr_d  = (seed == '0) ? ONE : seed;
                        end
                    end
                    LOAD: begin
                        if (w_set) begin
                            mask_d = mask_q | (ONE << w_set_bit);
                        end
                        if (w_last) begin
                            state_d = RUN;
                        end
                    end
                    RUN: begin
                        if (dout_valid_q && dout_ready) begin
                            dout_valid_d = 1'b0;
                        end
                        if (lfsr_q == '0) begin
                            // Lockup escape; not counted as a shift
                            lfsr_d = ONE;
                        end else if (!w_backpressure) begin
                            lfsr_d = {lfsr_q[SIZE-2:0], w_fb};
                            acc_d  = {acc_q[OUT_W-2:0], w_fb};
                            cnt_d  = cnt_q + 3'd1;
                            if (cnt_q == 3'd7) begin
                                dout_d       = {acc_q[OUT_W-2:0], w_fb};
                                dout_valid_d = 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            lfsr_q       <= '0;
            acc_q        <= '0;
            cnt_q        <= 3'd0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            lfsr_q       <= lfsr_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign running    = (state_q == RUN);

endmodule : tap_lfsr
`default_nettype wire

// File: tb/tb_tap_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : tb_tap_lfsr
// Description : Directed self-checking bench for tap_lfsr with SIZE=8 and
//               three tap fields: rotate-only mask, zero seed, reload,
//               maximal-length sequence with backpressure and enable gaps,
//               and reset in the middle of LOAD.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tap_lfsr;

    localparam int N    = 3;
    localparam int SIZE = 8;

    logic            clk = 1'b0;
    logic            res;
    logic            ena;
    logic [N*8-1:0]  taps;
    logic            taps_done;
    logic [SIZE-1:0] seed;
    logic            reload;
    logic [7:0]      dout;
    logic            dout_valid;
    logic            dout_ready;
    logic            running;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_b [0:255];

    always #5 clk = ~clk;

    tap_lfsr #(
        .NUM_OF_TAPS (N),
        .SIZE        (SIZE)
    ) dut (
        .clk        (clk),
        .res        (res),
        .ena        (ena),
        .taps       (taps),
        .taps_done  (taps_done),
        .seed       (seed),
        .reload     (reload),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .running    (running)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Bit-level model of x^8+x^6+x^5+x^4+1: h[n] = h[n-8]^h[n-6]^h[n-5]^h[n-4],
    // with the seed's bit p being the bit generated p+1 steps ago.
    task automatic build_model(input logic [7:0] sd);
        bit h [0:8+256*8-1];
        for (int p = 0; p < 8; p++) h[7-p] = sd[p];
        for (int n = 8; n < 8 + 256*8; n++) h[n] = h[n-8] ^ h[n-6] ^ h[n-5] ^ h[n-4];
        for (int j = 0; j < 256; j++)
            for (int b = 0; b < 8; b++) exp_b[j][7-b] = h[8 + 8*j + b];
    endtask

    // Ticks until dout_valid is seen or the budget runs out; n = ticks taken
    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (!dout_valid && n < limit) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int  n;
        int  gap;
        int  distinct;
        bit  seen [0:255];

        res = 1'b0; ena = 1'b1; taps = '0; taps_done = 1'b0; seed = '0;
        reload = 1'b0; dout_ready = 1'b1;
        tick(); tick();

        // Reset state
        chk("rst_dout", dout, 8'h00);
        chk("rst_valid", dout_valid, 1'b0);
        chk("rst_running", running, 1'b0);
        res = 1'b1;
        tick();

        // Rotate-only mask: all fields invalid (9, 0, 8 = SIZE), seed 01
        taps = {8'd8, 8'd0, 8'd9};
        seed = 8'h01;
        taps_done = 1'b1;
        tick(); tick(); tick();
        chk("rot_running_load", running, 1'b0);
        tick();
        chk("rot_running_run", running, 1'b1);
        taps_done = 1'b0;
        repeat (7) tick();
        chk("rot_valid_early", dout_valid, 1'b0);
        tick();
        chk("rot_valid_first", dout_valid, 1'b1);
        chk("rot_dout_first", dout, 8'h01);
        repeat (7) tick();
        chk("rot_valid_gap", dout_valid, 1'b0);
        tick();
        chk("rot_valid_second", dout_valid, 1'b1);
        chk("rot_dout_second", dout, 8'h01);

        // Reload in RUN while a byte is pending
        reload = 1'b1;
        tick();
        reload = 1'b0;
        chk("reload_valid", dout_valid, 1'b0);
        chk("reload_running", running, 1'b0);

        // Zero seed behaves as seed 1
        seed = 8'h00;
        taps_done = 1'b1;
        tick();
        taps_done = 1'b0;
        wait_valid(40, n);
        chk("zero_latency", n + 1, 12);
        chk("zero_dout", dout, 8'h01);
        reload = 1'b1;
        tick();
        reload = 1'b0;

        // Maximal-length run, taps 6,5,4, starting under backpressure
        build_model(8'h01);
        chk("model_byte0", exp_b[0], 8'h1C);
        taps = {8'd4, 8'd5, 8'd6};
        seed = 8'h01;
        dout_ready = 1'b0;
        taps_done = 1'b1;
        tick();
        taps_done = 1'b0;
        wait_valid(40, n);
        chk("ml_latency", n + 1, 12);
        chk("ml_byte0", dout, exp_b[0]);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp_dout_stable", dout, exp_b[0]);
        end
        chk("bp_valid_held", dout_valid, 1'b1);
        dout_ready = 1'b1;
        tick();
        chk("bp_release_valid", dout_valid, 1'b1);
        chk("bp_release_byte1", dout, exp_b[1]);
        seen[exp_b[0]] = 1'b1;
        seen[dout] = 1'b1;

        for (int j = 2; j < 256; j++) begin
            gap = 0;
            if (j == 11) begin
                tick(); tick(); tick();
                gap = 3;
                ena = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    tick();
                    gap++;
                    chk("ena_hold_valid", dout_valid, 1'b0);
                    chk("ena_hold_dout", dout, exp_b[10]);
                end
                ena = 1'b1;
            end
            tick();
            gap++;
            while (!dout_valid && gap < 40) begin
                tick();
                gap++;
            end
            chk("ml_gap", gap, (j == 11) ? 13 : 8);
            chk("ml_byte", dout, exp_b[j]);
            if (j < 255) seen[dout] = 1'b1;
        end
        // Byte 255 closes the cycle back onto byte 0
        chk("ml_period_wrap", dout, exp_b[0]);
        distinct = 0;
        for (int v = 1; v < 256; v++) if (seen[v]) distinct++;
        chk("ml_distinct_nonzero", distinct, 255);
        chk("ml_zero_never", seen[0], 1'b0);

        // Reset during LOAD (after field 0 is handled)
        reload = 1'b1;
        tick();
        reload = 1'b0;
        taps_done = 1'b1;
        tick();
        taps_done = 1'b0;
        tick();
        res = 1'b0;
        tick();
        chk("midload_dout", dout, 8'h00);
        chk("midload_valid", dout_valid, 1'b0);
        chk("midload_running", running, 1'b0);
        res = 1'b1;
        repeat (3) tick();
        chk("midload_idle", running, 1'b0);

        // Fresh run after reset reproduces the sequence start
        taps_done = 1'b1;
        tick();
        taps_done = 1'b0;
        wait_valid(40, n);
        chk("rerun_latency", n + 1, 12);
        chk("rerun_byte0", dout, exp_b[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_tap_lfsr
`default_nettype wire
